// File: rtl/luma_stats_pkg.sv
// luma_stats_pkg
// Shared types and helpers for the luma statistics block and the blocks
// that consume its report (e.g. the sync controller).
//   state_t        : frame tracker state (IDLE / ACCUM)
//   sum_t          : default-width luma sum (32 bits); modules size their
//                    own ports from their SUM_WIDTH parameter
//   min_sum_width  : smallest accumulator width that cannot overflow for a
//                    given pixel depth and frame geometry
package luma_stats_pkg;

  localparam int SUM_WIDTH_DEFAULT = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  typedef logic [SUM_WIDTH_DEFAULT-1:0] sum_t;

  // Worst case sum is (2^color_w - 1) * h * v, which fits in
  // color_w + clog2(h * v) bits.
  function automatic int min_sum_width(input int color_w, input int h, input int v);
    return color_w + $clog2(h * v);
  endfunction

endpackage

// File: rtl/luma_frame_stats_abs_diff_gt.sv
// abs_diff_gt
// Combinational unsigned magnitude comparison: gt = (|a - b| > thr).
// Ports:
//   a, b  in  WIDTH  unsigned operands
//   thr   in  WIDTH  threshold (strict greater-than)
//   gt    out 1      comparison result
module abs_diff_gt #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] thr,
  output logic             gt
);

  logic [WIDTH-1:0] diff;

  // Subtract the smaller from the larger so the difference never wraps.
  always_comb begin
    diff = (a >= b) ? (a - b) : (b - a);
    gt   = (diff > thr);
  end

endmodule

// File: rtl/luma_frame_stats.sv
// luma_frame_stats
// Per-frame luma statistics on the greyscale pixel stream. Accumulates the
// frame luma sum, checks line/frame geometry and flags scene cuts against
// the previous good frame. Emits one registered report per frame.
// Ports:
//   clk, aresetn      clock, asynchronous active-low reset
//   enable            sampled at start of frame; 0 ignores that frame
//   video_in_tdata    grey pixel, lane [COLOR_WIDTH-1:0] used
//   video_in_tvalid   beat valid (always accepted, no backpressure)
//   video_in_tuser    start of frame
//   video_in_tlast    end of line
//   cut_threshold     scene-cut threshold on |sum - prev_sum|
//   frame_sum         sum of last reported frame (held between reports)
//   stats_valid       one-cycle report pulse
//   scene_cut         cut flag, qualified by stats_valid
//   frame_err         one-cycle pulse on malformed / truncated frame
//   frame_count       number of good frames reported (wraps)
module luma_frame_stats
  import luma_stats_pkg::*;
#(
  parameter int COLOR_WIDTH = 8,
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int SUM_WIDTH   = 32,
  parameter int FCNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     enable,
  input  logic [3*COLOR_WIDTH-1:0] video_in_tdata,
  input  logic                     video_in_tvalid,
  input  logic                     video_in_tuser,
  input  logic                     video_in_tlast,
  input  logic [SUM_WIDTH-1:0]     cut_threshold,
  output logic [SUM_WIDTH-1:0]     frame_sum,
  output logic                     stats_valid,
  output logic                     scene_cut,
  output logic                     frame_err,
  output logic [FCNT_WIDTH-1:0]    frame_count
);

  if (SUM_WIDTH < min_sum_width(COLOR_WIDTH, H_ACTIVE, V_ACTIVE)) begin : g_width_check
    $error("luma_frame_stats: SUM_WIDTH too small for frame geometry");
  end

  localparam int PX_W = $clog2(H_ACTIVE + 1);
  localparam int LN_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [PX_W-1:0] PX_FULL = PX_W'(H_ACTIVE);
  localparam logic [LN_W-1:0] LN_LAST = LN_W'(V_ACTIVE - 1);

  state_t                 state_reg, state_next;
  logic [SUM_WIDTH-1:0]   sum_reg, sum_next;
  logic [PX_W-1:0]        px_cnt_reg, px_cnt_next;
  logic [LN_W-1:0]        line_cnt_reg, line_cnt_next;
  logic                   bad_reg, bad_next;
  logic [SUM_WIDTH-1:0]   prev_sum_reg, prev_sum_next;
  logic                   have_prev_reg, have_prev_next;
  logic [SUM_WIDTH-1:0]   frame_sum_reg, frame_sum_next;
  logic                   stats_valid_reg, stats_valid_next;
  logic                   scene_cut_reg, scene_cut_next;
  logic                   frame_err_reg, frame_err_next;
  logic [FCNT_WIDTH-1:0]  frame_count_reg, frame_count_next;

  // Lanes are identical after the greyscale filter; only lane 0 is needed.
  logic                   unused_lanes;
  assign unused_lanes = ^video_in_tdata[3*COLOR_WIDTH-1:COLOR_WIDTH];

  logic                   start_frame, early_sof, accept, close_frame;
  logic [SUM_WIDTH-1:0]   pix_ext, base_sum, sum_acc;
  logic [PX_W-1:0]        base_px, px_inc;
  logic [LN_W-1:0]        base_line;
  logic                   base_bad, line_full, bad_acc;
  logic                   cut_gt;

  // Compares the sum including the current beat, so the cut decision is
  // ready to register on the closing beat itself.
  abs_diff_gt #(
    .WIDTH (SUM_WIDTH)
  ) u_cut_cmp (
    .a   (sum_acc),
    .b   (prev_sum_reg),
    .thr (cut_threshold),
    .gt  (cut_gt)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg       <= IDLE;
      sum_reg         <= '0;
      px_cnt_reg      <= '0;
      line_cnt_reg    <= '0;
      bad_reg         <= 1'b0;
      prev_sum_reg    <= '0;
      have_prev_reg   <= 1'b0;
      frame_sum_reg   <= '0;
      stats_valid_reg <= 1'b0;
      scene_cut_reg   <= 1'b0;
      frame_err_reg   <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      sum_reg         <= sum_next;
      px_cnt_reg      <= px_cnt_next;
      line_cnt_reg    <= line_cnt_next;
      bad_reg         <= bad_next;
      prev_sum_reg    <= prev_sum_next;
      have_prev_reg   <= have_prev_next;
      frame_sum_reg   <= frame_sum_next;
      stats_valid_reg <= stats_valid_next;
      scene_cut_reg   <= scene_cut_next;
      frame_err_reg   <= frame_err_next;
      frame_count_reg <= frame_count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    sum_next         = sum_reg;
    px_cnt_next      = px_cnt_reg;
    line_cnt_next    = line_cnt_reg;
    bad_next         = bad_reg;
    prev_sum_next    = prev_sum_reg;
    have_prev_next   = have_prev_reg;
    frame_sum_next   = frame_sum_reg;
    stats_valid_next = 1'b0;
    scene_cut_next   = 1'b0;
    frame_err_next   = 1'b0;
    frame_count_next = frame_count_reg;

    start_frame = video_in_tvalid & video_in_tuser & enable;
    early_sof   = video_in_tvalid & video_in_tuser & (state_reg == ACCUM);
    accept      = start_frame |
                  (video_in_tvalid & ~video_in_tuser & (state_reg == ACCUM));

    // A start-of-frame beat is processed as the first beat of an empty
    // frame, so SOF+EOL on one beat naturally forms a 1-pixel line.
    base_sum  = start_frame ? '0   : sum_reg;
    base_px   = start_frame ? '0   : px_cnt_reg;
    base_line = start_frame ? '0   : line_cnt_reg;
    base_bad  = start_frame ? 1'b0 : bad_reg;

    pix_ext   = SUM_WIDTH'(video_in_tdata[COLOR_WIDTH-1:0]);
    sum_acc   = base_sum + pix_ext;
    px_inc    = (base_px == PX_FULL) ? base_px : base_px + PX_W'(1);
    line_full = (px_inc == PX_FULL);
    // Short line: tlast before H_ACTIVE. Overrun: H_ACTIVE reached without tlast.
    bad_acc   = base_bad | (video_in_tlast ? ~line_full : line_full);
    close_frame = accept & video_in_tlast & (base_line == LN_LAST);

    if (accept) begin
      state_next = ACCUM;
      sum_next   = sum_acc;
      bad_next   = bad_acc;
      if (video_in_tlast) begin
        px_cnt_next   = '0;
        line_cnt_next = base_line + LN_W'(1);
      end else begin
        px_cnt_next   = px_inc;
        line_cnt_next = base_line;
      end
    end

    if (early_sof) begin
      frame_err_next = 1'b1;
      if (!enable) begin
        state_next = IDLE;
      end
    end

    if (close_frame) begin
      state_next       = IDLE;
      stats_valid_next = 1'b1;
      frame_sum_next   = sum_acc;
      if (bad_acc) begin
        frame_err_next = 1'b1;
      end else begin
        scene_cut_next   = have_prev_reg & cut_gt;
        prev_sum_next    = sum_acc;
        have_prev_next   = 1'b1;
        frame_count_next = frame_count_reg + FCNT_WIDTH'(1);
      end
    end
  end

  assign frame_sum   = frame_sum_reg;
  assign stats_valid = stats_valid_reg;
  assign scene_cut   = scene_cut_reg;
  assign frame_err   = frame_err_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_luma_frame_stats.sv
// tb_luma_frame_stats
// Directed bench for luma_frame_stats with a 4x2 frame geometry. A
// frame-level reference model (lines collected as lengths, running sum)
// predicts the report every cycle; literal checks pin key reports.
module tb_luma_frame_stats;

  localparam int CW = 8;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int SW = 32;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable = 1'b0;
  logic [3*CW-1:0] video_in_tdata = '0;
  logic          video_in_tvalid = 1'b0;
  logic          video_in_tuser = 1'b0;
  logic          video_in_tlast = 1'b0;
  logic [SW-1:0] cut_threshold = 32'd50;
  logic [SW-1:0] frame_sum;
  logic          stats_valid;
  logic          scene_cut;
  logic          frame_err;
  logic [FW-1:0] frame_count;

  int checks = 0;
  int errors = 0;

  luma_frame_stats #(
    .COLOR_WIDTH (CW),
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .SUM_WIDTH   (SW),
    .FCNT_WIDTH  (FW)
  ) dut (
    .clk             (clk),
    .aresetn         (aresetn),
    .enable          (enable),
    .video_in_tdata  (video_in_tdata),
    .video_in_tvalid (video_in_tvalid),
    .video_in_tuser  (video_in_tuser),
    .video_in_tlast  (video_in_tlast),
    .cut_threshold   (cut_threshold),
    .frame_sum       (frame_sum),
    .stats_valid     (stats_valid),
    .scene_cut       (scene_cut),
    .frame_err       (frame_err),
    .frame_count     (frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit      m_active;
  int      m_lines[$];
  int      m_cur;
  longint  m_sum;
  longint  m_prev;
  bit      m_have_prev;
  bit      e_valid, e_err, e_cut;
  longint  e_sum;
  int      e_count;

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_active = 0; m_lines.delete(); m_cur = 0; m_sum = 0;
      m_prev = 0; m_have_prev = 0;
      e_valid = 0; e_err = 0; e_cut = 0; e_sum = 0; e_count = 0;
    end else begin
      e_valid = 0; e_err = 0; e_cut = 0;
      if (video_in_tvalid) begin
        if (video_in_tuser) begin
          if (m_active) e_err = 1;
          m_active = enable;
          m_lines.delete(); m_cur = 0; m_sum = 0;
        end
        if (m_active) begin
          m_sum += longint'(video_in_tdata[CW-1:0]);
          m_cur++;
          if (video_in_tlast) begin
            m_lines.push_back(m_cur);
            m_cur = 0;
            if (m_lines.size() == V) begin
              bit good;
              longint diff;
              good = 1;
              foreach (m_lines[i]) if (m_lines[i] != H) good = 0;
              e_valid = 1;
              e_sum = m_sum;
              if (good) begin
                diff = (m_sum > m_prev) ? m_sum - m_prev : m_prev - m_sum;
                e_cut = m_have_prev && (diff > longint'(cut_threshold));
                m_prev = m_sum;
                m_have_prev = 1;
                e_count = (e_count + 1) % 65536;
              end else begin
                e_err = 1;
              end
              m_active = 0;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("stats_valid", 64'(stats_valid), 64'(e_valid));
    chk("frame_err", 64'(frame_err), 64'(e_err));
    chk("frame_sum", 64'(frame_sum), 64'(e_sum));
    chk("frame_count", 64'(frame_count), 64'(e_count));
    if (e_valid) chk("scene_cut", 64'(scene_cut), 64'(e_cut));
    if (stats_valid || frame_err)
      $display("report t=%0t valid=%0d sum=%0d cut=%0d err=%0d count=%0d",
               $time, stats_valid, frame_sum, scene_cut, frame_err, frame_count);
  end

  // ---------------- stimulus ----------------
  task automatic beat(input int pix, input bit sof, input bit eol);
    logic [CW-1:0] p;
    p = pix[CW-1:0];
    video_in_tdata  = {p, p, p};
    video_in_tvalid = 1'b1;
    video_in_tuser  = sof;
    video_in_tlast  = eol;
    @(negedge clk);
    video_in_tvalid = 1'b0;
    video_in_tuser  = 1'b0;
    video_in_tlast  = 1'b0;
  endtask

  // Idle cycles with junk sideband to show non-valid cycles are ignored.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      video_in_tvalid = 1'b0;
      video_in_tdata  = 24'($urandom);
      video_in_tuser  = 1'($urandom);
      video_in_tlast  = 1'($urandom);
      @(negedge clk);
    end
    video_in_tuser = 1'b0;
    video_in_tlast = 1'b0;
  endtask

  task automatic send_line(input int val, input int len, input bit sof, input bit eol,
                           input int max_gap);
    for (int i = 0; i < len; i++) begin
      beat(val, sof && (i == 0), eol && (i == len - 1));
      if (max_gap > 0 && i != len - 1) gap($urandom_range(0, max_gap));
    end
  endtask

  task automatic send_frame(input int val, input int max_gap);
    send_line(val, H, 1'b1, 1'b1, max_gap);
    if (max_gap > 0) gap($urandom_range(0, max_gap));
    send_line(val, H, 1'b0, 1'b1, max_gap);
  endtask

  // Called right after the closing beat: the report is visible now.
  task automatic check_report(input string name, input int sum, input bit cut,
                              input bit err, input int count);
    chk({name, ".valid"}, 64'(stats_valid), 64'd1);
    chk({name, ".sum"}, 64'(frame_sum), 64'(sum));
    chk({name, ".cut"}, 64'(scene_cut), 64'(cut));
    chk({name, ".err"}, 64'(frame_err), 64'(err));
    chk({name, ".count"}, 64'(frame_count), 64'(count));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset.valid", 64'(stats_valid), 64'd0);
    chk("reset.sum", 64'(frame_sum), 64'd0);
    chk("reset.count", 64'(frame_count), 64'd0);
    chk("reset.err", 64'(frame_err), 64'd0);
    aresetn = 1'b1;
    enable  = 1'b1;
    gap(2);

    // Stray beats without SOF are dropped in IDLE.
    beat(99, 1'b0, 1'b1);
    gap(1);

    send_frame(10, 0);
    check_report("f1", 80, 1'b0, 1'b0, 1);
    gap(1);
    send_frame(20, 0);
    check_report("f2", 160, 1'b1, 1'b0, 2);
    gap(1);

    // |80-160| = 80 is not strictly greater than 80.
    cut_threshold = 32'd80;
    send_frame(10, 0);
    check_report("f3_thr_eq", 80, 1'b0, 1'b0, 3);
    cut_threshold = 32'd50;
    gap(1);

    // Short first line -> error report; good prev stays 80.
    send_line(30, 3, 1'b1, 1'b1, 0);
    send_line(30, 4, 1'b0, 1'b1, 0);
    check_report("short_line", 210, 1'b0, 1'b1, 3);
    gap(1);
    send_frame(25, 0);
    check_report("after_bad", 200, 1'b1, 1'b0, 4);
    gap(1);

    // Early SOF after 5 beats.
    send_line(9, 4, 1'b1, 1'b1, 0);
    send_line(9, 1, 1'b0, 1'b0, 0);
    beat(5, 1'b1, 1'b0);
    chk("early_sof.err", 64'(frame_err), 64'd1);
    chk("early_sof.valid", 64'(stats_valid), 64'd0);
    send_line(5, 3, 1'b0, 1'b1, 0);
    send_line(5, 4, 1'b0, 1'b1, 0);
    check_report("after_early", 40, 1'b1, 1'b0, 5);
    gap(1);

    // Back-to-back with random gaps; second SOF right after close.
    send_frame(7, 3);
    check_report("b2b_a", 56, 1'b0, 1'b0, 6);
    send_frame(12, 3);
    check_report("b2b_b", 96, 1'b0, 1'b0, 7);
    gap(2);

    // Line overrun: 6 pixels on line 0.
    send_line(2, 6, 1'b1, 1'b1, 0);
    send_line(2, 4, 1'b0, 1'b1, 0);
    check_report("overrun", 20, 1'b0, 1'b1, 7);
    gap(1);

    // SOF and EOL on the same beat: 1-pixel line.
    send_line(3, 1, 1'b1, 1'b1, 0);
    send_line(3, 4, 1'b0, 1'b1, 0);
    check_report("one_px_line", 15, 1'b0, 1'b1, 7);
    gap(1);

    // Reset mid-frame.
    send_line(33, 3, 1'b1, 1'b0, 0);
    #2 aresetn = 1'b0;
    @(negedge clk);
    chk("midreset.count", 64'(frame_count), 64'd0);
    chk("midreset.sum", 64'(frame_sum), 64'd0);
    chk("midreset.valid", 64'(stats_valid), 64'd0);
    @(negedge clk);
    aresetn = 1'b1;
    gap(1);

    enable = 1'b0;
    send_frame(50, 0);
    chk("ignored.valid", 64'(stats_valid), 64'd0);
    chk("ignored.err", 64'(frame_err), 64'd0);
    enable = 1'b1;
    gap(1);
    send_frame(40, 0);
    check_report("post_reset", 320, 1'b0, 1'b0, 1);
    gap(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
